qspi_xip_line_reader: RTL and testbench



---
 rtl/qspi_xip_pkg.sv | 22 ++
 rtl/qspi_sck_gen.sv | 44 ++++
 rtl/qspi_xip_line_reader.sv | 168 ++++++++++++++++
 tb/tb_qspi_xip_line_reader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_xip_pkg.sv
// Shared phase encoding and protocol constants for the QSPI XIP line reader.
package qspi_xip_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StMode,
        StDummy,
        StData,
        StDone
    } phase_e;

    localparam logic [7:0] QSPI_CMD_QIOR = 8'hEB;
    localparam logic [7:0] MODE_CONT     = 8'hA0;
    localparam logic [7:0] MODE_EXIT     = 8'h00;

    localparam int unsigned CMD_CLKS  = 8;
    localparam int unsigned ADDR_CLKS = 6;
    localparam int unsigned MODE_CLKS = 2;

endpackage

// File: rtl/qspi_sck_gen.sv
// SCK divider: toggles sck every SCK_DIV clk cycles while enabled, held low otherwise.
module qspi_sck_gen #(
    parameter int unsigned SCK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic sck_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned DivW = $clog2(SCK_DIV + 1);

    logic [DivW-1:0] cnt_q, cnt_d;
    logic            sck_q, sck_d;
    logic            tick;

    // Strobes flag the clk edge on which sck is about to change.
    always_comb begin
        tick   = en_i && (cnt_q == DivW'(SCK_DIV - 1));
        rise_o = tick && !sck_q;
        fall_o = tick && sck_q;
        cnt_d  = '0;
        sck_d  = 1'b0;
        if (en_i) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            sck_d = sck_q ^ tick;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign sck_o = sck_q;

endmodule

// File: rtl/qspi_xip_line_reader.sv
// Fetches one cache line from quad-I/O flash with 0xEB, entering or leaving
// continuous-read mode according to xip_en.
module qspi_xip_line_reader
    import qspi_xip_pkg::*;
#(
    parameter int unsigned LINE_SIZE  = 16,
    parameter int unsigned SCK_DIV    = 1,
    parameter int unsigned DUMMY_CLKS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [23:0]            addr,
    input  logic                   rd,
    input  logic                   xip_en,
    output logic                   busy,
    output logic                   done,
    output logic [LINE_SIZE*8-1:0] line,
    output logic                   sck,
    output logic                   ce_n,
    input  logic [3:0]             din,
    output logic [3:0]             dout,
    output logic                   douten
);

    localparam int unsigned LineW    = LINE_SIZE * 8;
    localparam int unsigned DataClks = 2 * LINE_SIZE;
    localparam int unsigned CntW     = $clog2((DataClks > 16) ? DataClks : 16);
    localparam logic [23:0] OffMask  = 24'(LINE_SIZE - 1);

    phase_e             state_q, state_d, next_ph;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [23:0]        addr_q, addr_d;
    logic               xip_q, xip_d;
    logic               cont_q, cont_d;
    logic [3:0]         dout_q, dout_d;
    logic [LineW-1:0]   fill_q, fill_d;
    logic [LineW-1:0]   line_q, line_d;
    logic               last, load;
    logic               sck_rise, sck_fall;

    // Nibble driven for a given phase and SCK index within that phase.
    function automatic logic [3:0] tx_nibble(input phase_e ph, input logic [CntW-1:0] idx,
                                             input logic [23:0] a, input logic [7:0] m);
        logic [3:0] nib;
        nib = 4'h0;
        case (ph)
            StCmd:   nib = {3'b000, QSPI_CMD_QIOR[3'd7 - idx[2:0]]};
            StAddr:  nib = 4'(a >> (4 * (5 - int'(idx))));
            StMode:  nib = idx[0] ? m[3:0] : m[7:4];
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

    assign ce_n = (state_q == StIdle) || (state_q == StDone);

    qspi_sck_gen #(
        .SCK_DIV (SCK_DIV)
    ) u_sck_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (!ce_n),
        .sck_o  (sck),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        xip_d   = xip_q;
        cont_d  = cont_q;
        dout_d  = dout_q;
        fill_d  = fill_q;
        line_d  = line_q;
        last    = 1'b0;
        next_ph = StIdle;
        load    = 1'b0;

        case (state_q)
            StCmd: begin
                last    = cnt_q == CntW'(CMD_CLKS - 1);
                next_ph = StAddr;
            end
            StAddr: begin
                last    = cnt_q == CntW'(ADDR_CLKS - 1);
                next_ph = StMode;
            end
            StMode: begin
                last    = cnt_q == CntW'(MODE_CLKS - 1);
                next_ph = (DUMMY_CLKS == 0) ? StData : StDummy;
            end
            StDummy: begin
                last    = cnt_q == CntW'(DUMMY_CLKS) - 1'b1;
                next_ph = StData;
            end
            StData: begin
                last    = cnt_q == CntW'(DataClks - 1);
                next_ph = StDone;
            end
            default: ;
        endcase

        case (state_q)
            StIdle: begin
                if (rd) begin
                    addr_d  = addr & ~OffMask;
                    xip_d   = xip_en;
                    cnt_d   = '0;
                    state_d = cont_q ? StAddr : StCmd;
                    load    = 1'b1;
                end
            end
            StDone: state_d = StIdle;
            default: begin
                // Nibble j of the data stream lands in nibble slot j^1 (high nibble first).
                if (sck_rise && state_q == StData) begin
                    fill_d[(int'(cnt_q) ^ 1) * 4 +: 4] = din;
                end
                if (sck_fall) begin
                    load  = 1'b1;
                    cnt_d = last ? '0 : cnt_q + 1'b1;
                    if (last) begin
                        state_d = next_ph;
                    end
                    if (last && state_q == StData) begin
                        line_d = fill_q;
                        cont_d = xip_q;
                    end
                end
            end
        endcase

        if (load) begin
            dout_d = tx_nibble(state_d, cnt_d, addr_d, xip_d ? MODE_CONT : MODE_EXIT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            xip_q   <= 1'b0;
            cont_q  <= 1'b0;
            dout_q  <= '0;
            fill_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            xip_q   <= xip_d;
            cont_q  <= cont_d;
            dout_q  <= dout_d;
            fill_q  <= fill_d;
            line_q  <= line_d;
        end
    end

    assign busy   = state_q != StIdle;
    assign done   = state_q == StDone;
    assign douten = (state_q == StCmd) || (state_q == StAddr) || (state_q == StMode);
    assign dout   = dout_q;
    assign line   = line_q;

endmodule

// File: tb/tb_qspi_xip_line_reader.sv
// Bench: two reader configurations, each talking to a behavioural quad-I/O flash.
module tb_qspi_xip_line_reader;

    localparam int NI = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [23:0]  addr [NI];
    logic         rd [NI];
    logic         xip [NI];
    logic         busy [NI];
    logic         done [NI];
    logic         sck [NI];
    logic         ce_n [NI];
    logic         douten [NI];
    logic [3:0]   dout [NI];
    logic [255:0] line_w [NI];
    logic [7:0]   fl_cmd_w [NI];
    logic [7:0]   fl_mode_w [NI];
    logic [23:0]  fl_addr_w [NI];
    int unsigned  fl_bad_w [NI];
    int unsigned  done_cnt_w [NI];

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [7:0]  key = 8'h10;
    bit          m_cont [NI];

    // Flash content for a line: byte k = key + k + addr[23:16].
    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned LS = (g == 0) ? 16 : 32;
        localparam int unsigned DV = (g == 0) ? 1 : 2;
        localparam int unsigned DC = (g == 0) ? 4 : 6;

        logic [LS*8-1:0] line_l;
        logic [3:0]      din_l = 4'h0;
        logic [7:0]      f_cmd = 8'h0;
        logic [7:0]      f_mode = 8'h0;
        logic [7:0]      f_byte;
        logic [23:0]     f_addr = 24'h0;
        logic [3:0]      p_dout = 4'h0;
        bit              f_cont = 1'b0, st_cont = 1'b0, p_sck = 1'b0, p_ce = 1'b1;
        int unsigned     nr = 0, nf = 0, hdr = 0, since = 0, k = 0, j = 0;
        int unsigned     n_done = 0, n_bad = 0;

        qspi_xip_line_reader #(
            .LINE_SIZE  (LS),
            .SCK_DIV    (DV),
            .DUMMY_CLKS (DC)
        ) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .addr   (addr[g]),
            .rd     (rd[g]),
            .xip_en (xip[g]),
            .busy   (busy[g]),
            .done   (done[g]),
            .line   (line_l),
            .sck    (sck[g]),
            .ce_n   (ce_n[g]),
            .din    (din_l),
            .dout   (dout[g]),
            .douten (douten[g])
        );

        assign line_w[g]     = 256'(line_l);
        assign fl_cmd_w[g]   = f_cmd;
        assign fl_mode_w[g]  = f_mode;
        assign fl_addr_w[g]  = f_addr;
        assign fl_bad_w[g]   = n_bad;
        assign done_cnt_w[g] = n_done;

        always @(negedge clk) begin
            if (done[g]) n_done++;
            if (!ce_n[g]) begin
                if (p_ce) begin
                    st_cont = f_cont;
                    nr = 0; nf = 0; since = 0;
                    hdr = (st_cont ? 0 : 8) + 8 + DC;
                    f_cmd = 8'h0; f_addr = 24'h0; f_mode = 8'h0;
                end else if (dout[g] !== p_dout && !(p_sck && !sck[g])) begin
                    n_bad++;
                end
                if (sck[g] && !p_sck) begin
                    if (nr != 0 && since != 2 * DV) n_bad++;
                    since = 0;
                    k = st_cont ? nr + 8 : nr;
                    if (k < 8) begin
                        f_cmd = {f_cmd[6:0], dout[g][0]};
                        if (!douten[g]) n_bad++;
                    end else if (k < 14) begin
                        f_addr = {f_addr[19:0], dout[g]};
                        if (!douten[g]) n_bad++;
                    end else if (k < 16) begin
                        f_mode = {f_mode[3:0], dout[g]};
                        if (!douten[g]) n_bad++;
                        if (k == 15) f_cont = (f_mode == 8'hA0);
                    end else if (douten[g]) begin
                        n_bad++;
                    end
                    nr++;
                end
                if (!sck[g] && p_sck) begin
                    nf++;
                    if (nf >= hdr) begin
                        j = nf - hdr;
                        f_byte = 8'(key + 8'(j / 2) + f_addr[23:16]);
                        din_l = (j % 2 == 0) ? f_byte[7:4] : f_byte[3:0];
                    end
                end
                since++;
            end else begin
                din_l = 4'h0;
                if (sck[g]) n_bad++;
            end
            p_sck  = sck[g];
            p_ce   = ce_n[g];
            p_dout = dout[g];
        end
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One line fetch on instance g; spam also pulses rd at cycles 10, 50 and the done cycle.
    task automatic fetch(input int g, input logic [23:0] a, input bit x, input bit spam);
        int unsigned  ls, dv, dc, n, lat, cyc, d0;
        bit           c0;
        logic [255:0] exp_line;
        ls = (g == 0) ? 16 : 32;
        dv = (g == 0) ? 1 : 2;
        dc = (g == 0) ? 4 : 6;
        c0 = m_cont[g];
        n = (c0 ? 0 : 8) + 8 + dc + 2 * ls;
        lat = 1 + 2 * dv * n;
        d0 = done_cnt_w[g];
        exp_line = '0;
        for (int i = 0; i < int'(ls); i++) exp_line[8*i +: 8] = 8'(key + 8'(i) + a[23:16]);

        @(negedge clk);
        addr[g] = a; xip[g] = x; rd[g] = 1'b1;
        @(posedge clk); #1;
        rd[g] = 1'b0; addr[g] = 24'($urandom); xip[g] = 1'($urandom);
        cyc = 1;
        chk("accept_busy", busy[g], 1'b1);
        chk("accept_ce_n", ce_n[g], 1'b0);
        while (!done[g] && cyc < 5000) begin
            rd[g] = spam && (cyc == 10 || cyc == 50);
            @(posedge clk); #1;
            cyc++;
        end
        rd[g] = 1'b0;
        chk("latency", cyc, lat);
        chk("done_busy", busy[g], 1'b1);
        chk("done_ce_n", ce_n[g], 1'b1);
        chk("done_sck", sck[g], 1'b0);
        chk("line", line_w[g], exp_line);
        chk("flash_cmd", fl_cmd_w[g], c0 ? 8'h00 : 8'hEB);
        chk("flash_addr", fl_addr_w[g], a & ~24'(ls - 1));
        chk("flash_mode", fl_mode_w[g], x ? 8'hA0 : 8'h00);
        chk("flash_protocol", fl_bad_w[g], 0);
        m_cont[g] = x;
        rd[g] = spam;
        @(posedge clk); #1;
        rd[g] = 1'b0;
        chk("idle_busy", busy[g], 1'b0);
        chk("done_pulses", done_cnt_w[g] - d0, 1);
        chk("line_hold", line_w[g], exp_line);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned bad;
        for (int g = 0; g < NI; g++) begin
            rd[g] = 1'b0; xip[g] = 1'b0; addr[g] = 24'h0; m_cont[g] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rst_ce_n", ce_n[0], 1'b1);
        chk("rst_sck", sck[0], 1'b0);
        rst_n = 1'b1;
        #1;
        chk("idle_busy0", busy[0], 1'b0);
        chk("idle_done0", done[0], 1'b0);
        chk("idle_douten0", douten[0], 1'b0);
        chk("idle_dout0", dout[0], 4'h0);
        chk("idle_line0", line_w[0], '0);
        chk("idle_line1", line_w[1], '0);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy[0] !== 1'b0 || done[0] !== 1'b0 || ce_n[0] !== 1'b1 || sck[0] !== 1'b0 ||
                douten[0] !== 1'b0 || line_w[0] !== '0) bad++;
        end
        chk("idle_hold", bad, 0);

        key = 8'h10;
        fetch(0, 24'h000100, 1'b1, 1'b0);
        chk("line_byte0", line_w[0][7:0], 8'h10);
        chk("line_byte15", line_w[0][127:120], 8'h1F);
        fetch(0, 24'h000200, 1'b1, 1'b0);
        fetch(0, 24'h00034C, 1'b0, 1'b0);
        fetch(0, 24'h000400, 1'b1, 1'b0);
        fetch(0, 24'h000500, 1'b1, 1'b1);

        key = 8'h5A;
        @(negedge clk);
        addr[0] = 24'h0A0B30; xip[0] = 1'b0; rd[0] = 1'b1;
        @(posedge clk); #1;
        rd[0] = 1'b0;
        repeat (60) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_ce_n", ce_n[0], 1'b1);
        chk("midrst_sck", sck[0], 1'b0);
        chk("midrst_busy", busy[0], 1'b0);
        chk("midrst_douten", douten[0], 1'b0);
        chk("midrst_dout", dout[0], 4'h0);
        chk("midrst_line", line_w[0], '0);
        @(negedge clk);
        rst_n = 1'b1;
        m_cont[0] = 1'b0; m_cont[1] = 1'b0;
        fetch(0, 24'h123456, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            key = 8'($urandom);
            fetch(0, 24'($urandom), 1'($urandom), 1'b0);
        end

        key = 8'h10;
        fetch(1, 24'h000100, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            key = 8'($urandom);
            fetch(1, 24'($urandom), 1'($urandom), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
